rad_cdc_mcp_rx_packer: RTL
==========================

Name: rad_cdc_mcp_rx_packer

Overview:
- B-domain consumer that sits directly downstream of the multi-cycle-path CDC receiver.
- Accepts WIDTH-bit words from the bdata/bvalid/bload interface and drives bload itself.
- Packs RATIO words into one wide beat and presents beats on a valid/ready stream through a DEPTH-entry output buffer.
- A flush request emits a partial beat, qualified by a per-word keep mask.

Parameters:
WIDTH, 8, width of one word received from the CDC receiver
RATIO, 4, words per output beat (>=2)
DEPTH, 2, output buffer entries (>=1)

Ports:
clk  input  1  B-domain clock; single clock for the whole block
rst  input  1  synchronous, active-high reset
bdata  input  WIDTH  word from CDC receiver
bvalid  input  1  bdata holds an unconsumed word
bload  output  1  consume pulse to CDC receiver
flush  input  1  single-cycle request to emit the partial beat
odata  output  WIDTH*RATIO  head beat; word 0 occupies bits [WIDTH-1:0]
okeep  output  RATIO  bit i set = word i valid in odata
ovalid  output  1  head beat valid
oready  input  1  downstream accepts head beat
obusy  output  1  partial words, buffered beats, or pending flush present

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: bload=0, ovalid=0, odata=0, okeep=0, obusy=0.
  - Accumulator count acc_cnt=0; flush_pend=0; buffer empty.
- Reset asserted mid-operation discards the partial beat and all buffered beats. No bload is issued while rst=1.
- Internal state:
  - Accumulator registers for RATIO-1 words.
  - acc_cnt, range 0..RATIO-1, width $clog2(RATIO).
  - flush_pend, a sticky bit.
  - DEPTH-entry buffer holding {data, keep}.
- space = (buffer count < DEPTH). Space does not take credit from a same-cycle pop, so there is no combinational oready->bload path.
- bload = !rst && bvalid && !flush_pend && (acc_cnt != RATIO-1 || space). bload is combinational from bvalid.
- On bload with acc_cnt < RATIO-1:
  - Store bdata into slot acc_cnt.
  - acc_cnt++.
- On bload with acc_cnt == RATIO-1:
  - Push the full beat: keep = all ones, last word taken directly from bdata.
  - acc_cnt -> 0.
- Flush arrives with acc_cnt==0 and no word loaded that cycle: ignored, no beat.
- Flush arrives otherwise: flush_pend set. Then, on the first cycle with space:
  - Push the partial beat: keep = low acc_cnt bits set; unused words zero.
  - acc_cnt -> 0; flush_pend -> 0.
  - The push may occur in the same cycle the flush is seen.
- Flush and bload in the same cycle: the loaded word is included first.
  - If that load completes a full beat, the full beat is pushed and flush becomes a no-op (nothing left).
  - Otherwise the loaded word becomes part of the partial beat, and the push occurs on the next cycle with space.
- Flush while flush_pend=1: absorbed, no second beat.
- While flush_pend=1, bload stays 0.
- Buffer:
  - First-word-fall-through.
  - ovalid = count != 0; odata/okeep show the head entry.
  - Pop on ovalid && oready.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
- Latency: the final word loaded at edge N into an empty buffer gives ovalid=1 in the cycle after edge N.
- obusy = (acc_cnt!=0) || flush_pend || ovalid. Registered-state derived only.
- Stability: while ovalid && !oready, odata and okeep hold.
- Ordering: beats leave in push order. Word order within a beat is arrival order.

Decomposition:
- Package rad_cdc_mcp_rx_pkg holds:
  - Word and beat typedefs parameterised by WIDTH/RATIO.
  - keep_t.
  - A keep-mask function mapping a count to its low-bits mask.
- One sub-module, rad_cdc_mcp_rx_fifo: synchronous FWFT buffer with parameters DEPTH and payload width.
  - Ports: clk, rst, push, din, pop, dout, count.
- Packer control stays in the top module.

Test Plan:
1. Basic pack, WIDTH=8, RATIO=4: bvalid continuously with words 0x11,0x22,0x33,0x44, oready=1 -> four bload pulses; one beat with odata=0x44332211, okeep=4'b1111; ovalid high for one cycle, the cycle after the 4th load.
2. Flush partial: load 0xAA,0xBB then pulse flush -> beat with odata=0x0000BBAA, okeep=4'b0011; then acc_cnt=0 and obusy=0.
3. Backpressure: oready=0 with DEPTH=2, feed 12 words.
   - Two beats buffered; bload stops after the 11th word, acc_cnt=3.
   - odata stable while stalled.
   - Raising oready releases beats in order 1,2,3.
4. Flush collisions:
   - Flush with acc_cnt=3 and bload of the 4th word in the same cycle -> one full beat, okeep=1111, no extra beat.
   - Flush with acc_cnt=0 -> no beat.
   - Flush while buffer full -> flush_pend held, bload=0, partial beat pushed once space appears.
5. Reset mid-operation: rst=1 for one cycle after 2 words loaded and 1 beat buffered -> next cycle ovalid=0, okeep=0, obusy=0, bload=0; subsequent words pack from slot 0.
6. Simultaneous push/pop at full: DEPTH=1, ovalid=1, oready=1 on the cycle the 4th word arrives -> bload stays 0 that cycle because of no pop credit; the word is loaded on the following cycle; no beat lost or duplicated.

Source files
------------

// File: rtl/rad_cdc_mcp_rx_pkg.sv
// Shared types and helpers for the multi-cycle-path CDC receive-side packer.
package rad_cdc_mcp_rx_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned RATIO_DEF = 4;
  localparam int unsigned KEEP_MAX  = 32;

  typedef logic [WIDTH_DEF-1:0]           word_t;
  typedef logic [WIDTH_DEF*RATIO_DEF-1:0] beat_t;
  typedef logic [KEEP_MAX-1:0]            keep_t;

  // Low cnt bits set; callers truncate to their RATIO.
  function automatic keep_t keep_mask(input int unsigned cnt);
    keep_t m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      if (i < cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rad_cdc_mcp_rx_fifo.sv
// Synchronous first-word-fall-through buffer; head entry visible on dout, zero when empty.
module rad_cdc_mcp_rx_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rad_cdc_mcp_rx_packer.sv
// Packs RATIO words from the CDC receiver into wide beats; flush emits a keep-qualified partial beat.
module rad_cdc_mcp_rx_packer
  import rad_cdc_mcp_rx_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RATIO = RATIO_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       bdata,
  input  logic                   bvalid,
  output logic                   bload,
  input  logic                   flush,
  output logic [WIDTH*RATIO-1:0] odata,
  output logic [RATIO-1:0]       okeep,
  output logic                   ovalid,
  input  logic                   oready,
  output logic                   obusy
);

  localparam int unsigned AW = $clog2(RATIO);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = WIDTH * RATIO;
  localparam logic [AW-1:0] ACC_LAST = AW'(RATIO - 1);

  logic [WIDTH-1:0]    acc [RATIO-1];
  logic [AW-1:0]       acc_cnt;
  logic                flush_pend;
  logic [CW-1:0]       fifo_cnt;
  logic                space, last, flush_set, full_push, part_push, push, pop;
  logic [RATIO-1:0]    part_keep, push_keep;
  logic [BW-1:0]       push_data;
  logic [BW+RATIO-1:0] fifo_din, fifo_dout;

  // No credit from a same-cycle pop, keeping oready out of the bload path.
  assign space     = fifo_cnt < CW'(DEPTH);
  assign last      = acc_cnt == ACC_LAST;
  assign bload     = !rst && bvalid && !flush_pend && (!last || space);
  assign full_push = bload && last;
  assign flush_set = flush && (bload ? !last : (acc_cnt != '0));
  assign part_push = space && (flush_pend || (flush && !bload && (acc_cnt != '0)));
  assign push      = full_push || part_push;
  assign part_keep = RATIO'(keep_mask(32'(acc_cnt)));

  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < RATIO - 1; i++) begin
      if (part_keep[i]) push_data[i*WIDTH +: WIDTH] = acc[i];
    end
    if (full_push) push_data[(RATIO-1)*WIDTH +: WIDTH] = bdata;
    push_keep = full_push ? '1 : part_keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= (flush_pend || flush_set) && !part_push;
      if (push)       acc_cnt <= '0;
      else if (bload) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bload && !last) acc[acc_cnt] <= bdata;
  end

  assign fifo_din = {push_keep, push_data};

  rad_cdc_mcp_rx_fifo #(
    .DEPTH (DEPTH),
    .DW    (BW + RATIO)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  assign ovalid = fifo_cnt != '0;
  assign pop    = ovalid && oready;
  assign odata  = fifo_dout[BW-1:0];
  assign okeep  = fifo_dout[BW +: RATIO];
  assign obusy  = (acc_cnt != '0) || flush_pend || ovalid;

endmodule
